tpu_ctrl: RTL and testbench
===========================

Name: tpu_ctrl

Overview:
- Sequencing controller for the TPU 4x4 systolic array. Computes C[m x n] = A[m x k] * B[k x n].
- Tiles the problem into ARRAY_SIZE x ARRAY_SIZE output blocks.
- Per tile: issues GBUFF_A/GBUFF_B reads, clears and feeds the PE array, waits for skew drain, then writes result rows to GBUFF_OUT.
- Sits inside top between the global buffers and the systolic array; drives top-level done.

Parameters:
- ARRAY_SIZE, 4: systolic array edge; elements per 32-bit buffer word.
- ADDR_W, 8: global buffer address width (matches GBUFF_ADDR_SIZE).
- PE_LAT, 1: cycles from pe_valid until the operand is accumulated in the PE.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low (asserted when 0, sampled on rising clk)
- start  in  1  request computation; sampled only in IDLE
- m  in  4  rows of A
- k  in  4  cols of A / rows of B
- n  in  4  cols of B
- done  out  1  computation complete; held high until start=0
- busy  out  1  high in FEED/WAIT/WRITE
- a_rd_en  out  1  GBUFF_A read enable
- a_addr  out  ADDR_W  GBUFF_A word address
- b_rd_en  out  1  GBUFF_B read enable
- b_addr  out  ADDR_W  GBUFF_B word address
- pe_clear  out  1  clear all PE accumulators
- pe_valid  out  1  operand data from the buffers is valid this cycle
- out_wr_en  out  1  GBUFF_OUT write enable
- out_addr  out  ADDR_W  GBUFF_OUT word address
- out_row_sel  out  2  array row muxed onto the GBUFF_OUT write data
- cycle_cnt  out  16  performance counter (see Optional Feature)

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE. All outputs and counters are 0. Applies at any point, including mid-tile; there is no partial write-back after reset.
- Derived quantities, latched when start is accepted:
  - MT = ceil(m/4), NT = ceil(n/4).
  - Tile order: mt outer, nt inner.
- Buffer layouts:
  - GBUFF_A word (mt*k + kk) = A rows 4mt..4mt+3, column kk.
  - GBUFF_B word (nt*k + kk) = B row kk, columns 4nt..4nt+3.
  - GBUFF_OUT is row-major with NT words per row. out_addr = (4mt + r)*NT + nt.
- Buffers have 1-cycle read latency.
- State machine:
  - IDLE:
    - start=1 with m, k, n all nonzero: latch m, k, n; clear tile counters; go to FEED.
    - start=1 with any of m, k, n zero: go to DONE; no reads, no writes.
    - start=0: stay in IDLE.
  - FEED, k cycles, kk = 0..k-1:
    - a_rd_en = b_rd_en = 1; addresses as above.
    - pe_clear=1 only on kk=0.
    - pe_valid is a_rd_en delayed 1 cycle.
  - WAIT: 1 + 2*(ARRAY_SIZE-1) + PE_LAT cycles (8 at defaults). Read enables are 0; the final pe_valid falls in the first WAIT cycle.
  - WRITE, ARRAY_SIZE cycles, r = 0..3:
    - out_row_sel = r; out_addr as above.
    - out_wr_en = 1 only if 4mt + r < m. Rows past m burn the cycle with no write.
  - After WRITE:
    - Advance nt, then mt.
    - If tiles remain: go to FEED for the next tile.
    - Otherwise: go to DONE.
  - DONE:
    - done=1.
    - start=0: go to IDLE.
    - start=1: stay in DONE. A held-high start never retriggers.
- Per-tile latency: k + 3*ARRAY_SIZE - 1 + PE_LAT cycles (k+12 at defaults).
- Address arithmetic is unsigned, ADDR_W bits wide. The maximum configuration (m = n = 15, k = 15) fits in 8 bits.
- start and dimension changes while busy are ignored.

Optional Feature:
- Macro: TPU_CTRL_PERF_CNT_EN.
- Enabled:
  - cycle_cnt clears on start acceptance and increments every cycle while busy=1.
  - It freezes in DONE and is readable until the next accepted start. It saturates at 16'hFFFF.
- Disabled: cycle_cnt is tied to 0 and the counter logic is absent.

Test Plan:
- m=k=n=4, start at cycle 0:
  - Expected: 4 reads at a_addr 0..3 and b_addr 0..3; 4 writes at out_addr 0..3.
  - done=1 at cycle 17.
  - cycle_cnt=16 when TPU_CTRL_PERF_CNT_EN is defined.
- m=5, k=3, n=9:
  - Expected: 6 tiles, 15 writes.
  - The mt=1 tiles write only out_addr 12, 13, 14, with row_sel=0.
  - done at cycle 91; cycle_cnt=90.
- m=0, k=4, n=4:
  - Expected: DONE one cycle after start; no rd_en or wr_en pulses; cycle_cnt=0.
- start held high after done:
  - Expected: done stays 1 and there is no second run.
  - After start=0: IDLE next cycle; done=0.
- rst=0 asserted during WAIT of tile 2 (m=n=8, k=4):
  - Expected: all outputs 0 next cycle, state IDLE.
  - A fresh start reruns from tile 0 with a_addr=0.
- start pulsed while busy with different m, k, n:
  - Expected: ignored; the original write sequence and addresses are unchanged.

Source files
------------

// File: rtl/tpu_ctrl_if.sv
// Host-side bundle of the TPU sequencing controller: command/status plus the
// global-buffer and PE-array control strobes. master = host, slave = tpu_ctrl.
interface tpu_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [3:0]        m;
  logic [3:0]        k;
  logic [3:0]        n;
  logic              done;
  logic              busy;
  logic              a_rd_en;
  logic [ADDR_W-1:0] a_addr;
  logic              b_rd_en;
  logic [ADDR_W-1:0] b_addr;
  logic              pe_clear;
  logic              pe_valid;
  logic              out_wr_en;
  logic [ADDR_W-1:0] out_addr;
  logic [1:0]        out_row_sel;
  logic [15:0]       cycle_cnt;

  modport master (
    output start, m, k, n,
    input  done, busy, a_rd_en, a_addr, b_rd_en, b_addr, pe_clear, pe_valid,
           out_wr_en, out_addr, out_row_sel, cycle_cnt
  );

  modport slave (
    input  start, m, k, n,
    output done, busy, a_rd_en, a_addr, b_rd_en, b_addr, pe_clear, pe_valid,
           out_wr_en, out_addr, out_row_sel, cycle_cnt
  );
endinterface

// File: rtl/tpu_ctrl.sv
// Tile sequencer for the systolic array: FEED -> WAIT (skew drain) -> WRITE per
// output tile. Define TPU_CTRL_PERF_CNT_EN to build the busy-cycle counter.
module tpu_ctrl #(
  parameter int ARRAY_SIZE = 4,
  parameter int ADDR_W     = 8,
  parameter int PE_LAT     = 1
) (
  input logic       clk,
  input logic       rst,
  tpu_ctrl_if.slave bus
);
  localparam int WAIT_CYC = 1 + 2 * (ARRAY_SIZE - 1) + PE_LAT;

  typedef enum logic [2:0] {S_IDLE, S_FEED, S_WAIT, S_WRITE, S_DONE} state_e;

  state_e            state_q;
  logic [7:0]        cnt_q;
  logic [3:0]        m_q, k_q, mt_num_q, nt_num_q, mt_q, nt_q;
  logic [ADDR_W-1:0] row_q;
  logic              done_q, busy_q, a_rd_en_q, b_rd_en_q, pe_clear_q, pe_valid_q;
  logic              out_wr_en_q;
  logic [ADDR_W-1:0] a_addr_q, b_addr_q, out_addr_q;
  logic [1:0]        out_row_sel_q;

  logic              dims_zero, last_nt, last_tile;
  logic [3:0]        mt_num_d, nt_num_d, mt_nx, nt_nx;
  logic [ADDR_W-1:0] a_base_nx, b_base_nx, row0, row0_addr;

  assign dims_zero = (bus.m == 4'd0) || (bus.k == 4'd0) || (bus.n == 4'd0);
  assign mt_num_d  = 4'((5'(bus.m) + 5'(ARRAY_SIZE - 1)) / 5'(ARRAY_SIZE));
  assign nt_num_d  = 4'((5'(bus.n) + 5'(ARRAY_SIZE - 1)) / 5'(ARRAY_SIZE));

  // Tile walk: nt is the inner index, mt advances when nt wraps.
  assign last_nt   = (nt_q == nt_num_q - 4'd1);
  assign last_tile = last_nt && (mt_q == mt_num_q - 4'd1);
  assign nt_nx     = last_nt ? 4'd0 : nt_q + 4'd1;
  assign mt_nx     = last_nt ? mt_q + 4'd1 : mt_q;
  assign a_base_nx = ADDR_W'(mt_nx) * ADDR_W'(k_q);
  assign b_base_nx = ADDR_W'(nt_nx) * ADDR_W'(k_q);
  assign row0      = ADDR_W'(mt_q) * ADDR_W'(ARRAY_SIZE);
  assign row0_addr = row0 * ADDR_W'(nt_num_q) + ADDR_W'(nt_q);

  // NOTE: every register here is a plain flop with a few bits of state, so all
  // of them take the synchronous reset; there is no storage array to exempt.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      m_q           <= '0;
      k_q           <= '0;
      mt_num_q      <= '0;
      nt_num_q      <= '0;
      mt_q          <= '0;
      nt_q          <= '0;
      row_q         <= '0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      a_rd_en_q     <= 1'b0;
      b_rd_en_q     <= 1'b0;
      pe_clear_q    <= 1'b0;
      pe_valid_q    <= 1'b0;
      out_wr_en_q   <= 1'b0;
      a_addr_q      <= '0;
      b_addr_q      <= '0;
      out_addr_q    <= '0;
      out_row_sel_q <= '0;
    end else begin
      // NOTE: non-blocking throughout, so these defaults are simply overridden
      // by later assignments below and every read sees the pre-edge value.
      pe_valid_q  <= a_rd_en_q;
      a_rd_en_q   <= 1'b0;
      b_rd_en_q   <= 1'b0;
      pe_clear_q  <= 1'b0;
      out_wr_en_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start && dims_zero) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else if (bus.start) begin
            state_q    <= S_FEED;
            busy_q     <= 1'b1;
            m_q        <= bus.m;
            k_q        <= bus.k;
            mt_num_q   <= mt_num_d;
            nt_num_q   <= nt_num_d;
            mt_q       <= '0;
            nt_q       <= '0;
            cnt_q      <= '0;
            a_addr_q   <= '0;
            b_addr_q   <= '0;
            a_rd_en_q  <= 1'b1;
            b_rd_en_q  <= 1'b1;
            pe_clear_q <= 1'b1;
          end
        end
        S_FEED: begin
          if (cnt_q == 8'(k_q) - 8'd1) begin
            state_q <= S_WAIT;
            cnt_q   <= '0;
          end else begin
            cnt_q     <= cnt_q + 8'd1;
            a_addr_q  <= a_addr_q + ADDR_W'(1);
            b_addr_q  <= b_addr_q + ADDR_W'(1);
            a_rd_en_q <= 1'b1;
            b_rd_en_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt_q == 8'(WAIT_CYC - 1)) begin
            state_q       <= S_WRITE;
            cnt_q         <= '0;
            row_q         <= row0;
            out_addr_q    <= row0_addr;
            out_row_sel_q <= '0;
            out_wr_en_q   <= (row0 < ADDR_W'(m_q));
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_WRITE: begin
          if (cnt_q == 8'(ARRAY_SIZE - 1)) begin
            cnt_q <= '0;
            mt_q  <= mt_nx;
            nt_q  <= nt_nx;
            if (last_tile) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q    <= S_FEED;
              a_addr_q   <= a_base_nx;
              b_addr_q   <= b_base_nx;
              a_rd_en_q  <= 1'b1;
              b_rd_en_q  <= 1'b1;
              pe_clear_q <= 1'b1;
            end
          end else begin
            // Rows beyond m still take their cycle, just without a write.
            cnt_q         <= cnt_q + 8'd1;
            row_q         <= row_q + ADDR_W'(1);
            out_addr_q    <= out_addr_q + ADDR_W'(nt_num_q);
            out_row_sel_q <= out_row_sel_q + 2'd1;
            out_wr_en_q   <= (row_q + ADDR_W'(1) < ADDR_W'(m_q));
          end
        end
        S_DONE: begin
          if (!bus.start) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.done        = done_q;
  assign bus.busy        = busy_q;
  assign bus.a_rd_en     = a_rd_en_q;
  assign bus.a_addr      = a_addr_q;
  assign bus.b_rd_en     = b_rd_en_q;
  assign bus.b_addr      = b_addr_q;
  assign bus.pe_clear    = pe_clear_q;
  assign bus.pe_valid    = pe_valid_q;
  assign bus.out_wr_en   = out_wr_en_q;
  assign bus.out_addr    = out_addr_q;
  assign bus.out_row_sel = out_row_sel_q;

`ifdef TPU_CTRL_PERF_CNT_EN
  logic [15:0] cycle_cnt_q;

  // Frozen outside busy so the last run's count stays readable in DONE/IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_cnt_q <= '0;
    end else if (state_q == S_IDLE && bus.start) begin
      cycle_cnt_q <= '0;
    end else if (busy_q && cycle_cnt_q != 16'hFFFF) begin
      cycle_cnt_q <= cycle_cnt_q + 16'd1;
    end
  end

  assign bus.cycle_cnt = cycle_cnt_q;
`else
  assign bus.cycle_cnt = '0;
`endif
endmodule

// File: tb/tb_tpu_ctrl.sv
// Self-checking bench for tpu_ctrl: every cycle of each job is compared against
// a per-cycle trace derived from the tile schedule (read/drain/write phases).
module tb_tpu_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  tpu_ctrl_if #(.ADDR_W(8)) bus ();

  tpu_ctrl #(.ARRAY_SIZE(4), .ADDR_W(8), .PE_LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        done;
    logic        busy;
    logic        a_rd_en;
    logic [7:0]  a_addr;
    logic        b_rd_en;
    logic [7:0]  b_addr;
    logic        pe_clear;
    logic        pe_valid;
    logic        out_wr_en;
    logic [7:0]  out_addr;
    logic [1:0]  out_row_sel;
    logic [15:0] cycle_cnt;
  } obs_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int cyc, input obs_t obs, input obs_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.done        = bus.done;
    o.busy        = bus.busy;
    o.a_rd_en     = bus.a_rd_en;
    o.a_addr      = bus.a_addr;
    o.b_rd_en     = bus.b_rd_en;
    o.b_addr      = bus.b_addr;
    o.pe_clear    = bus.pe_clear;
    o.pe_valid    = bus.pe_valid;
    o.out_wr_en   = bus.out_wr_en;
    o.out_addr    = bus.out_addr;
    o.out_row_sel = bus.out_row_sel;
    o.cycle_cnt   = bus.cycle_cnt;
    return o;
  endfunction

  // Addresses only carry meaning while their strobe is high.
  function automatic obs_t mask(input obs_t o);
    obs_t r = o;
    if (!r.a_rd_en) r.a_addr = '0;
    if (!r.b_rd_en) r.b_addr = '0;
    if (!r.out_wr_en) begin
      r.out_addr    = '0;
      r.out_row_sel = '0;
    end
    return r;
  endfunction

  // Cycle c counts from the cycle in which start is first seen (c = 0).
  function automatic int done_cycle(input int m, input int k, input int n);
    if (m == 0 || k == 0 || n == 0) return 1;
    return 1 + ((m + 3) / 4) * ((n + 3) / 4) * (k + 12);
  endfunction

  function automatic obs_t model(input int c, input int m, input int k, input int n,
                                 input int s);
    obs_t e = '0;
    int d  = done_cycle(m, k, n);
    int lt = k + 12;
    int nt_cnt = (n + 3) / 4;
    int t, p, mt, nt, r;
    if (!(m == 0 || k == 0 || n == 0) && c >= 1 && c < d) begin
      t  = (c - 1) / lt;
      p  = (c - 1) % lt;
      mt = t / nt_cnt;
      nt = t % nt_cnt;
      e.busy = 1'b1;
      if (p < k) begin
        e.a_rd_en  = 1'b1;
        e.b_rd_en  = 1'b1;
        e.a_addr   = 8'(mt * k + p);
        e.b_addr   = 8'(nt * k + p);
        e.pe_clear = (p == 0);
      end
      e.pe_valid = (p >= 1 && p <= k);
      if (p >= k + 8) begin
        r = p - k - 8;
        if (4 * mt + r < m) begin
          e.out_wr_en   = 1'b1;
          e.out_addr    = 8'((4 * mt + r) * nt_cnt + nt);
          e.out_row_sel = 2'(r);
        end
      end
    end
    e.done = (c >= d) && (c <= ((s > d) ? s : d));
`ifdef TPU_CTRL_PERF_CNT_EN
    if (!(m == 0 || k == 0 || n == 0)) e.cycle_cnt = 16'((c - 1 < d - 1) ? c - 1 : d - 1);
`endif
    return e;
  endfunction

  // start is high for cycles 0..s-1; optional busy-time glitch and mid-run reset.
  task automatic run_job(input string tag, input int m, input int k, input int n,
                         input int s, input int glitch, input int abort_at);
    int d    = done_cycle(m, k, n);
    int last = ((s > d) ? s : d) + 1;
    obs_t zero = '0;
    bus.m = 4'(m);
    bus.k = 4'(k);
    bus.n = 4'(n);
    bus.start = 1'b1;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      check(tag, c, mask(sample()), model(c, m, k, n, s));
      if (c == abort_at) begin
        rst = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check({tag, "_rst"}, c + 1, sample(), zero);
        rst = 1'b1;
        return;
      end
      if (c == glitch) begin
        bus.start = 1'b1;
        bus.m = 4'($urandom_range(0, 15));
        bus.k = 4'($urandom_range(0, 15));
        bus.n = 4'($urandom_range(0, 15));
      end else begin
        bus.start = (c < s);
        bus.m = 4'(m);
        bus.k = 4'(k);
        bus.n = 4'(n);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    obs_t zero = '0;
    int m, k, n, d, s, g;
    bus.start = 1'b0;
    bus.m = '0;
    bus.k = '0;
    bus.n = '0;

    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset", 0, sample(), zero);
    rst = 1'b1;
    @(negedge clk);

    run_job("m4k4n4", 4, 4, 4, 1, 0, 0);
    run_job("m5k3n9", 5, 3, 9, 1, 0, 0);
    run_job("m0_zero", 0, 4, 4, 1, 0, 0);
    run_job("hold_start", 4, 4, 4, done_cycle(4, 4, 4) + 4, 0, 0);
    run_job("abort_wait", 8, 4, 8, 1, 0, 40);
    run_job("rerun", 8, 4, 8, 1, 0, 0);
    run_job("glitch", 4, 4, 4, 1, 6, 0);
    run_job("max_dims", 15, 15, 15, 1, 0, 0);

    for (int i = 0; i < 8; i++) begin
      m = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15));
      k = int'($urandom_range(1, 15));
      n = int'($urandom_range(1, 15));
      d = done_cycle(m, k, n);
      s = ($urandom_range(0, 1) == 0) ? 1 : d + int'($urandom_range(0, 3));
      g = (d > 2 && s == 1) ? int'($urandom_range(1, d - 1)) : 0;
      run_job($sformatf("rand%0d", i), m, k, n, s, g, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
